decoder: RTL and testbench

DECODER -- requirements
Module: decoder

---
 rtl/decoder_if.sv | 27 ++
 rtl/decoder.sv | 92 +++++++++
 tb/tb_decoder.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/decoder_if.sv
// rtl/decoder_if.sv - instruction-in / decoded-fields-out bundle for the RV32I decoder
interface decoder_if;
    logic [31:0] i_instruction;
    logic [6:0]  o_opcode;
    logic [4:0]  o_rd;
    logic [2:0]  o_funct3;
    logic [4:0]  o_rs1;
    logic [4:0]  o_rs2;
    logic [6:0]  o_funct7;
    logic [11:0] o_immediate;
    logic [31:0] o_imm32;
    logic [2:0]  o_format;
    logic        o_illegal;
    logic        o_illegal_seen;

    modport master (
        output i_instruction,
        input  o_opcode, o_rd, o_funct3, o_rs1, o_rs2, o_funct7,
        input  o_immediate, o_imm32, o_format, o_illegal, o_illegal_seen
    );

    modport slave (
        input  i_instruction,
        output o_opcode, o_rd, o_funct3, o_rs1, o_rs2, o_funct7,
        output o_immediate, o_imm32, o_format, o_illegal, o_illegal_seen
    );
endinterface

// File: rtl/decoder.sv
// rtl/decoder.sv - combinational RV32I field/immediate decoder with sticky illegal flag
module decoder (
    input  logic     i_clk,
    input  logic     i_rst,
    decoder_if.slave bus
);
    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    logic [31:0] instr;
    logic [2:0]  fmt;
    logic        sign;

    assign instr = bus.i_instruction;
    assign sign  = instr[31];

    // Raw field slices are passed through regardless of opcode legality.
    assign bus.o_opcode = instr[6:0];
    assign bus.o_rd     = instr[11:7];
    assign bus.o_funct3 = instr[14:12];
    assign bus.o_rs1    = instr[19:15];
    assign bus.o_rs2    = instr[24:20];
    assign bus.o_funct7 = instr[31:25];

    // Opcode to format; anything unlisted (including compressed encodings) is illegal.
    always_comb begin
        fmt = FMT_ILL;
        case (instr[6:0])
            7'b0110011: fmt = FMT_R;
            7'b0010011,
            7'b0000011,
            7'b1100111,
            7'b1110011,
            7'b0001111: fmt = FMT_I;
            7'b0100011: fmt = FMT_S;
            7'b1100011: fmt = FMT_B;
            7'b0110111,
            7'b0010111: fmt = FMT_U;
            7'b1101111: fmt = FMT_J;
            default:    fmt = FMT_ILL;
        endcase
    end

    assign bus.o_format  = fmt;
    assign bus.o_illegal = (fmt == FMT_ILL);

    // Immediate assembly; B and J drop the always-zero LSB from the 12-bit field only.
    always_comb begin
        bus.o_immediate = 12'h000;
        bus.o_imm32     = 32'h0;
        case (fmt)
            FMT_I: begin
                bus.o_immediate = instr[31:20];
                bus.o_imm32     = {{20{sign}}, instr[31:20]};
            end
            FMT_S: begin
                bus.o_immediate = {instr[31:25], instr[11:7]};
                bus.o_imm32     = {{20{sign}}, instr[31:25], instr[11:7]};
            end
            FMT_B: begin
                bus.o_immediate = {instr[31], instr[7], instr[30:25], instr[11:8]};
                bus.o_imm32     = {{19{sign}}, instr[31], instr[7], instr[30:25],
                                   instr[11:8], 1'b0};
            end
            FMT_U: begin
                bus.o_imm32 = {instr[31:12], 12'h000};
            end
            FMT_J: begin
                bus.o_imm32 = {{11{sign}}, instr[31], instr[19:12], instr[20],
                               instr[30:21], 1'b0};
            end
            default: begin
                bus.o_immediate = 12'h000;
                bus.o_imm32     = 32'h0;
            end
        endcase
    end

    // Sticky illegal flag: reset wins over an illegal word on the same edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bus.o_illegal_seen <= 1'b0;
        end else begin
            bus.o_illegal_seen <= bus.o_illegal_seen | bus.o_illegal;
        end
    end
endmodule

// File: tb/tb_decoder.sv
// tb/tb_decoder.sv - randomized self-checking bench for decoder against a behavioural model
module tb_decoder;
    logic clk;
    logic rst;
    logic exp_seen;
    int   tests;
    int   fails;

    decoder_if bus ();

    decoder dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  fmt;
        logic [11:0] imm;
        logic [31:0] imm32;
    } exp_t;

    logic [6:0] legal_ops [10];
    initial begin
        legal_ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h0f, 7'h23, 7'h63, 7'h37, 7'h17};
    end

    // Reference: immediates computed as signed integer offsets from the ISA bit layout.
    function automatic exp_t model(input logic [31:0] w);
        exp_t e;
        int   v;
        logic [6:0] op;
        op = w[6:0];
        e.fmt = 3'd7;
        e.imm = 12'h000;
        e.imm32 = 32'h0;
        if (op == 7'h33) begin
            e.fmt = 3'd0;
        end else if (op inside {7'h13, 7'h03, 7'h67, 7'h73, 7'h0f}) begin
            e.fmt = 3'd1;
            e.imm = w[31:20];
            v = int'(w[31:20]);
            if (w[31]) v = v - 4096;
            e.imm32 = 32'(v);
        end else if (op == 7'h23) begin
            e.fmt = 3'd2;
            e.imm = {w[31:25], w[11:7]};
            v = int'(w[31:25]) * 32 + int'(w[11:7]);
            if (w[31]) v = v - 4096;
            e.imm32 = 32'(v);
        end else if (op == 7'h63) begin
            e.fmt = 3'd3;
            e.imm = {w[31], w[7], w[30:25], w[11:8]};
            v = int'(w[31]) * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
            if (w[31]) v = v - 8192;
            e.imm32 = 32'(v);
        end else if (op == 7'h37 || op == 7'h17) begin
            e.fmt = 3'd4;
            e.imm32 = w & 32'hFFFF_F000;
        end else if (op == 7'h6f) begin
            e.fmt = 3'd5;
            v = int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
            if (w[31]) v = v - (1 << 20);
            e.imm32 = 32'(v);
        end
        return e;
    endfunction

    // Expected sticky flag, tracked on the same edges the DUT samples.
    always @(posedge clk) begin
        if (rst) exp_seen <= 1'b0;
        else     exp_seen <= exp_seen | (model(bus.i_instruction).fmt == 3'd7);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_comb(input logic [31:0] w);
        exp_t e;
        e = model(w);
        check("opcode", 32'(bus.o_opcode), 32'(w[6:0]));
        check("rd", 32'(bus.o_rd), 32'(w[11:7]));
        check("funct3", 32'(bus.o_funct3), 32'(w[14:12]));
        check("rs1", 32'(bus.o_rs1), 32'(w[19:15]));
        check("rs2", 32'(bus.o_rs2), 32'(w[24:20]));
        check("funct7", 32'(bus.o_funct7), 32'(w[31:25]));
        check("format", 32'(bus.o_format), 32'(e.fmt));
        check("illegal", 32'(bus.o_illegal), 32'(e.fmt == 3'd7));
        check("immediate", 32'(bus.o_immediate), 32'(e.imm));
        check("imm32", bus.o_imm32, e.imm32);
    endtask

    // Drive a word at the falling edge, check decode, then check the flag after one rising edge.
    task automatic apply(input logic [31:0] w, input logic r);
        bus.i_instruction = w;
        rst = r;
        #1;
        check_comb(w);
        @(negedge clk);
        check("illegal_seen", 32'(bus.o_illegal_seen), 32'(exp_seen));
    endtask

    initial begin
        logic [31:0] w;
        tests = 0;
        fails = 0;
        rst = 1'b1;
        bus.i_instruction = 32'h0000_0000;
        @(negedge clk);
        check("seen_after_reset", 32'(bus.o_illegal_seen), 32'h0);

        // Short illegal glitch between edges must not latch.
        rst = 1'b0;
        bus.i_instruction = 32'h0000_0013;
        #1;
        bus.i_instruction = 32'h0000_0000;
        #2;
        bus.i_instruction = 32'h0000_0013;
        @(negedge clk);
        check("seen_glitch", 32'(bus.o_illegal_seen), 32'h0);

        // Directed vectors with literal expectations.
        apply(32'h0000_0013, 1'b0);
        bus.i_instruction = 32'h0000_0013; #1;
        check("nop_format", 32'(bus.o_format), 32'd1);
        check("nop_imm", 32'(bus.o_immediate), 32'h000);
        check("nop_illegal", 32'(bus.o_illegal), 32'h0);
        bus.i_instruction = 32'h0010_8093; #1;
        check("addi1_rd", 32'(bus.o_rd), 32'd1);
        check("addi1_rs1", 32'(bus.o_rs1), 32'd1);
        check("addi1_imm", 32'(bus.o_immediate), 32'h001);
        check("addi1_imm32", bus.o_imm32, 32'h0000_0001);
        bus.i_instruction = 32'hFFFF_8113; #1;
        check("addim1_rd", 32'(bus.o_rd), 32'd2);
        check("addim1_rs1", 32'(bus.o_rs1), 32'd31);
        check("addim1_imm", 32'(bus.o_immediate), 32'hFFF);
        check("addim1_imm32", bus.o_imm32, 32'hFFFF_FFFF);
        bus.i_instruction = 32'hFE11_2E23; #1;
        check("sw_format", 32'(bus.o_format), 32'd2);
        check("sw_rs1", 32'(bus.o_rs1), 32'd2);
        check("sw_rs2", 32'(bus.o_rs2), 32'd1);
        check("sw_imm", 32'(bus.o_immediate), 32'hFFC);
        check("sw_imm32", bus.o_imm32, 32'hFFFF_FFFC);
        bus.i_instruction = 32'h0000_10B7; #1;
        check("lui_format", 32'(bus.o_format), 32'd4);
        check("lui_rd", 32'(bus.o_rd), 32'd1);
        check("lui_imm32", bus.o_imm32, 32'h0000_1000);
        check("lui_imm", 32'(bus.o_immediate), 32'h000);
        @(negedge clk);

        // Sticky sequence.
        apply(32'h0000_0000, 1'b0);
        check("zero_illegal", 32'(bus.o_illegal), 32'h1);
        check("sticky_set", 32'(bus.o_illegal_seen), 32'h1);
        apply(32'h0000_0013, 1'b0);
        check("sticky_hold", 32'(bus.o_illegal_seen), 32'h1);
        apply(32'hFFFF_FFFC, 1'b1);
        check("reset_priority", 32'(bus.o_illegal_seen), 32'h0);

        // Randomized sweep with occasional resets.
        for (int i = 0; i < 400; i++) begin
            w = $urandom;
            if ($urandom_range(0, 1) == 0) w[6:0] = legal_ops[$urandom_range(0, 9)];
            else if ($urandom_range(0, 3) == 0) w[6:0] = 7'h6f;
            apply(w, $urandom_range(0, 31) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
